overlay_fader: RTL and testbench

- Parametrised successor to the fullscreen image drawer.
- Draws an indexed image ROM at a runtime (x0,y0) position with power-of-two scaling and a transparent palette index.
- Cross-fades the image over the background stream through a frame-synchronous show/hold/hide state machine.
- Sits between the background renderer and the VGA output; used for game-over, title and round-start screens.

---
 rtl/overlay_fader.sv | 231 +++++++++++++++++++++++
 tb/tb_overlay_fader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_fader.sv
// Indexed-image overlay with power-of-two scaling, transparency and a
// frame-synchronous cross-fade over the background pixel stream.
module overlay_fader #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int ADDR_W      = 17,
  parameter int IDX_W       = 3,
  parameter int SCALE_SHIFT = 1,
  parameter int TRANSP_IDX  = 0,
  parameter int ROM_LAT     = 1,
  parameter int FADE_FRAMES = 2,
  parameter int HOLD_FRAMES = 0,
  parameter int H_LAST      = 799,
  parameter int V_LAST      = 524
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        x0,
  input  logic [9:0]        y0,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  input  logic              start,
  input  logic              hide,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              active,
  output logic [4:0]        level,
  output logic              done
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FADE_IN  = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_FADE_OUT = 2'd3;

  localparam int CNT_W = 16;
  localparam logic [11:0]       WIN_W    = 12'(IMG_W << SCALE_SHIFT);
  localparam logic [11:0]       WIN_H    = 12'(IMG_H << SCALE_SHIFT);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [CNT_W-1:0]  FADE_END = CNT_W'(FADE_FRAMES - 1);
  localparam logic [CNT_W-1:0]  HOLD_END = CNT_W'(HOLD_FRAMES - 1);

  typedef struct packed {
    logic        win;
    logic        blank;
    logic [11:0] bg;
  } pix_t;

  // ---------------- window and address ----------------
  logic [11:0] draw_x_w, draw_y_w, x0_w, y0_w;
  logic        in_win;
  logic [9:0]  dx_off, dy_off, dx_src, dy_src;

  // 12-bit compares so x0 + scaled width cannot wrap
  assign draw_x_w = {2'b00, DrawX};
  assign draw_y_w = {2'b00, DrawY};
  assign x0_w     = {2'b00, x0};
  assign y0_w     = {2'b00, y0};
  assign in_win   = (draw_x_w >= x0_w) && (draw_x_w < x0_w + WIN_W) &&
                    (draw_y_w >= y0_w) && (draw_y_w < y0_w + WIN_H);

  assign dx_off = DrawX - x0;
  assign dy_off = DrawY - y0;
  assign dx_src = dx_off >> SCALE_SHIFT;
  assign dy_src = dy_off >> SCALE_SHIFT;

  assign rom_address = in_win ? (ADDR_W'(dy_src) * IMG_W_A + ADDR_W'(dx_src)) : '0;

  // ---------------- alignment pipeline ----------------
  pix_t pix_in;
  pix_t pipe_reg [ROM_LAT];

  assign pix_in = '{win: in_win, blank: blank, bg: {bg_red, bg_green, bg_blue}};

  generate
    for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        always_ff @(posedge vga_clk) begin
          if (reset) pipe_reg[gi] <= '0;
          else       pipe_reg[gi] <= pix_in;
        end
      end else begin : g_rest
        always_ff @(posedge vga_clk) begin
          if (reset) pipe_reg[gi] <= '0;
          else       pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  // ---------------- fade state machine ----------------
  logic [1:0]       state_reg, state_next;
  logic [4:0]       level_reg, level_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             tick;

  assign tick = (DrawX == 10'(H_LAST)) && (DrawY == 10'(V_LAST));

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FADE_IN;
          cnt_next   = '0;
        end
      end
      ST_FADE_IN: begin
        if (hide) begin
          state_next = ST_FADE_OUT;
          cnt_next   = '0;
        end else if (level_reg == 5'd16) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end else if (tick) begin
          if (cnt_reg == FADE_END) begin
            cnt_next   = '0;
            level_next = level_reg + 5'd1;
            if (level_reg == 5'd15) state_next = ST_HOLD;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (hide) begin
          state_next = ST_FADE_OUT;
          cnt_next   = '0;
        end else if ((HOLD_FRAMES != 0) && tick) begin
          if (cnt_reg == HOLD_END) begin
            state_next = ST_FADE_OUT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_FADE_OUT: begin
        if (start) begin
          state_next = ST_FADE_IN;
          cnt_next   = '0;
        end else if (level_reg == 5'd0) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else if (tick) begin
          if (cnt_reg == FADE_END) begin
            cnt_next   = '0;
            level_next = level_reg - 5'd1;
            if (level_reg == 5'd1) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      level_reg <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  // ---------------- colour mix ----------------
  function automatic logic [3:0] mix_ch(input logic [3:0] p, input logic [3:0] b,
                                        input logic [4:0] lvl);
    logic [8:0] acc;
    acc = 9'(p) * 9'(lvl) + 9'(b) * (9'd16 - 9'(lvl));
    return 4'(acc >> 4);
  endfunction

  pix_t        tail;
  logic        ov_opaque;
  logic [11:0] rgb_reg, rgb_next;

  assign tail      = pipe_reg[ROM_LAT-1];
  assign ov_opaque = tail.win && (rom_q != IDX_W'(TRANSP_IDX)) && (state_reg != ST_IDLE);

  always_comb begin
    rgb_next = '0;
    if (tail.blank) begin
      if (!ov_opaque) rgb_next = tail.bg;
      else rgb_next = {mix_ch(pal_red,   tail.bg[11:8], level_reg),
                       mix_ch(pal_green, tail.bg[7:4],  level_reg),
                       mix_ch(pal_blue,  tail.bg[3:0],  level_reg)};
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) rgb_reg <= '0;
    else       rgb_reg <= rgb_next;
  end

  assign red    = rgb_reg[11:8];
  assign green  = rgb_reg[7:4];
  assign blue   = rgb_reg[3:0];
  assign active = (state_reg != ST_IDLE);
  assign level  = level_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_overlay_fader.sv
// Self-checking bench for overlay_fader: fixed vectors, hand sequences for the
// fade state machine, and randomized pixels against an arithmetic model.
module tb_overlay_fader;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic        reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0, x0 = '0, y0 = '0;
  logic        blank = 1'b0;
  logic [3:0]  bg_red = '0, bg_green = '0, bg_blue = '0;
  logic        start = 1'b0, hide = 1'b0;

  logic [16:0] rom_address, rom_address_h;
  logic [2:0]  rom_q = '0, rom_q_h = '0;
  logic [3:0]  pal_red, pal_green, pal_blue, pal_red_h, pal_green_h, pal_blue_h;
  logic [3:0]  red, green, blue, red_h, green_h, blue_h;
  logic        active, active_h, done, done_h;
  logic [4:0]  level, level_h;

  logic [11:0] pal_tab [8];
  int          force_idx = -1;
  int          done_cnt = 0, done_cnt_h = 0;
  int          n_checks = 0, n_errors = 0;

  function automatic int rom_fn(input int a);
    return a % 7;
  endfunction

  always @(posedge vga_clk) begin
    rom_q   <= (force_idx >= 0) ? 3'(force_idx) : 3'(rom_fn(int'(rom_address)));
    rom_q_h <= (force_idx >= 0) ? 3'(force_idx) : 3'(rom_fn(int'(rom_address_h)));
  end

  assign {pal_red, pal_green, pal_blue}       = pal_tab[rom_q];
  assign {pal_red_h, pal_green_h, pal_blue_h} = pal_tab[rom_q_h];

  always @(negedge vga_clk) begin
    if (done)   done_cnt   <= done_cnt + 1;
    if (done_h) done_cnt_h <= done_cnt_h + 1;
  end

  overlay_fader #(.FADE_FRAMES(2), .HOLD_FRAMES(0)) u_dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .x0(x0), .y0(y0), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .start(start), .hide(hide), .rom_address(rom_address), .rom_q(rom_q),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .active(active), .level(level), .done(done));

  overlay_fader #(.FADE_FRAMES(2), .HOLD_FRAMES(3)) u_hold (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .x0(x0), .y0(y0), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .start(start), .hide(hide), .rom_address(rom_address_h), .rom_q(rom_q_h),
    .pal_red(pal_red_h), .pal_green(pal_green_h), .pal_blue(pal_blue_h),
    .red(red_h), .green(green_h), .blue(blue_h), .active(active_h), .level(level_h),
    .done(done_h));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  function automatic int rgb();
    return int'({red, green, blue});
  endfunction

  function automatic int rgb_h();
    return int'({red_h, green_h, blue_h});
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      DrawX = 10'd799; DrawY = 10'd524;
      cyc(1);
      DrawX = 10'd0;   DrawY = 10'd0;
      cyc(1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_hide();
    hide = 1'b1; cyc(1); hide = 1'b0;
  endtask

  task automatic set_bg(input int c);
    {bg_red, bg_green, bg_blue} = 12'(c);
  endtask

  // Reference model: 640x480 window, 2x2 pixel replication, linear blend.
  function automatic bit m_in(input int dx, input int dy, input int xo, input int yo);
    return (dx >= xo) && (dx < xo + 640) && (dy >= yo) && (dy < yo + 480);
  endfunction

  function automatic int m_addr(input int dx, input int dy, input int xo, input int yo);
    if (!m_in(dx, dy, xo, yo)) return 0;
    return ((dy - yo) / 2) * 320 + (dx - xo) / 2;
  endfunction

  function automatic int m_rgb(input int dx, input int dy, input int xo, input int yo,
                               input int bgc, input bit blk, input int lvl, input bit idle);
    int idx, p, b, res;
    if (!blk) return 0;
    idx = rom_fn(m_addr(dx, dy, xo, yo));
    if (!m_in(dx, dy, xo, yo) || idle || idx == 0) return bgc;
    res = 0;
    for (int c = 0; c < 3; c++) begin
      p = (int'(pal_tab[idx]) >> (4 * c)) & 15;
      b = (bgc >> (4 * c)) & 15;
      res += ((p * lvl + b * (16 - lvl)) / 16) << (4 * c);
    end
    return res;
  endfunction

  task automatic run_random(input int lvl, input bit idle, input int n);
    int q[$];
    int dx, dy, xo, yo, bgc;
    bit blk;
    for (int i = 0; i < n; i++) begin
      @(posedge vga_clk); #1;
      if (q.size() == 2) check($sformatf("rnd L%0d rgb", lvl), rgb(), q.pop_front());
      dx  = $urandom_range(0, 799);
      dy  = $urandom_range(0, 524);
      if (dx == 799 && dy == 524) dy = 0;
      xo  = $urandom_range(0, 400);
      yo  = $urandom_range(0, 200);
      bgc = $urandom_range(0, 4095);
      blk = ($urandom_range(0, 4) != 0);
      DrawX = 10'(dx); DrawY = 10'(dy); x0 = 10'(xo); y0 = 10'(yo);
      blank = blk; set_bg(bgc);
      #1;
      check($sformatf("rnd addr (%0d,%0d)@(%0d,%0d)", dx, dy, xo, yo),
            int'(rom_address), m_addr(dx, dy, xo, yo));
      q.push_back(m_rgb(dx, dy, xo, yo, bgc, blk, lvl, idle));
    end
    repeat (2) begin
      @(posedge vga_clk); #1;
      check($sformatf("rnd L%0d rgb tail", lvl), rgb(), q.pop_front());
    end
    DrawX = 10'd0; DrawY = 10'd0; x0 = 10'd100; y0 = 10'd50;
  endtask

  typedef struct {
    int dx;
    int dy;
    bit blk;
    int bgc;
    int addr;
    int rgb;
  } vec_t;

  vec_t vecs [12];
  int   done_base;

  initial begin
    // x0=100, y0=50, HOLD at level 16, default palette {i+8, 15-i, 2i}
    vecs[0]  = '{99,  50,  1'b1, 'h456, 0,     'h456};
    vecs[1]  = '{100, 50,  1'b1, 'h456, 0,     'h456};
    vecs[2]  = '{101, 50,  1'b1, 'h456, 0,     'h456};
    vecs[3]  = '{102, 50,  1'b1, 'h456, 1,     'h9E2};
    vecs[4]  = '{739, 50,  1'b1, 'h123, 319,   'hCB8};
    vecs[5]  = '{740, 50,  1'b1, 'h123, 0,     'h123};
    vecs[6]  = '{100, 529, 1'b1, 'h789, 76480, 'hDAA};
    vecs[7]  = '{100, 530, 1'b1, 'h789, 0,     'h789};
    vecs[8]  = '{110, 53,  1'b1, 'h000, 325,   'hBC6};
    vecs[9]  = '{102, 50,  1'b0, 'h456, 1,     'h000};
    vecs[10] = '{100, 49,  1'b1, 'hFED, 0,     'hFED};
    vecs[11] = '{739, 529, 1'b1, 'h321, 76799, 'hAD4};
    for (int i = 0; i < 8; i++) pal_tab[i] = {4'(i + 8), 4'(15 - i), 4'(2 * i)};

    // reset state
    cyc(3);
    reset = 1'b0;
    x0 = 10'd100; y0 = 10'd50;
    cyc(1);
    check("reset level", int'(level), 0);
    check("reset active", int'(active), 0);
    check("reset done", int'(done), 0);
    check("reset rgb", rgb(), 0);

    // IDLE: opaque in-window pixel shows background, latency 2
    pal_tab[1] = 12'hFFF; force_idx = 1;
    DrawX = 10'd102; DrawY = 10'd50; blank = 1'b0; set_bg('h357);
    cyc(2);
    blank = 1'b1;
    cyc(1);
    check("idle latency-1 rgb", rgb(), 0);
    cyc(1);
    check("idle bg rgb", rgb(), 'h357);
    pal_tab[1] = {4'd9, 4'd14, 4'd2}; force_idx = -1;
    DrawX = 10'd0; DrawY = 10'd0;

    // reset during FADE_IN at level 7
    pulse_start();
    do_ticks(14);
    check("fadein L7 level", int'(level), 7);
    check("fadein L7 active", int'(active), 1);
    check("fadein L7 rgb", rgb(), 'h357);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("abort level", int'(level), 0);
    check("abort active", int'(active), 0);
    check("abort rgb", rgb(), 0);
    check("abort done", int'(done), 0);
    do_ticks(4);
    check("abort no done", done_cnt, 0);
    check("abort stays idle", int'(active), 0);

    // fade in with blend check at level 8, then exact palette at 16
    pulse_start();
    check("start active", int'(active), 1);
    do_ticks(16);
    check("fadein L8 level", int'(level), 8);
    force_idx = 2; pal_tab[2] = 12'hAAA; set_bg('h222);
    DrawX = 10'd102; DrawY = 10'd50;
    cyc(2);
    check("blend L8 rgb", rgb(), 'h666);
    DrawX = 10'd0; DrawY = 10'd0;
    do_ticks(15);
    check("fadein 31 ticks level", int'(level), 15);
    do_ticks(1);
    check("fadein 32 ticks level", int'(level), 16);
    DrawX = 10'd102; DrawY = 10'd50;
    cyc(2);
    check("L16 exact pal rgb", rgb(), 'hAAA);
    force_idx = -1; pal_tab[2] = {4'd10, 4'd13, 4'd4};
    DrawX = 10'd0; DrawY = 10'd0;
    do_ticks(5);
    check("hold indefinite level", int'(level), 16);
    check("hold indefinite active", int'(active), 1);

    // window / address vectors in HOLD
    for (int i = 0; i < 12; i++) begin
      DrawX = 10'(vecs[i].dx); DrawY = 10'(vecs[i].dy);
      blank = vecs[i].blk; set_bg(vecs[i].bgc);
      #1;
      check($sformatf("vec%0d addr", i), int'(rom_address), vecs[i].addr);
      cyc(2);
      check($sformatf("vec%0d rgb", i), rgb(), vecs[i].rgb);
    end
    DrawX = 10'd0; DrawY = 10'd0; blank = 1'b1;

    run_random(16, 1'b0, 150);

    // hide at 16, re-start at 5, then full fade out
    pulse_hide();
    do_ticks(1);
    check("fadeout 1 tick level", int'(level), 16);
    do_ticks(21);
    check("fadeout L5 level", int'(level), 5);
    run_random(5, 1'b0, 100);
    pulse_start();
    do_ticks(22);
    check("restart L16 level", int'(level), 16);
    check("restart no done", done_cnt, 0);
    pulse_hide();
    do_ticks(31);
    check("fadeout L1 level", int'(level), 1);
    check("fadeout L1 active", int'(active), 1);
    check("fadeout L1 no done", done_cnt, 0);
    do_ticks(1);
    check("fadeout end level", int'(level), 0);
    check("fadeout end active", int'(active), 0);
    check("fadeout one done", done_cnt, 1);
    do_ticks(4);
    check("idle done stays", done_cnt, 1);
    run_random(0, 1'b1, 60);

    // HOLD_FRAMES=3 auto-hide with blank=0 throughout
    reset = 1'b1; cyc(1); reset = 1'b0;
    done_base = done_cnt_h;
    x0 = 10'd0; y0 = 10'd0; blank = 1'b0; force_idx = 3; set_bg('hFFF);
    pulse_start();
    do_ticks(32);
    check("auto L16 level", int'(level_h), 16);
    check("auto rgb blank", rgb_h(), 0);
    for (int t = 1; t <= 4; t++) begin
      do_ticks(1);
      check($sformatf("auto hold tick%0d level", t), int'(level_h), 16);
      check($sformatf("auto hold tick%0d rgb", t), rgb_h(), 0);
    end
    do_ticks(1);
    check("auto tick5 level", int'(level_h), 15);
    check("manual-hold tick5 level", int'(level), 16);
    do_ticks(30);
    check("auto end level", int'(level_h), 0);
    check("auto end active", int'(active_h), 0);
    check("auto end rgb", rgb_h(), 0);
    check("auto one done", done_cnt_h - done_base, 1);
    force_idx = -1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
